// File: rtl/axi_sim_selftest.sv
// AXI4-Lite write/read-back self-test subsystem.
// A traffic master writes a pattern into a memory-model slave, reads it back and
// compares. Traffic crosses a monitoring passthrough that counts the AW and AR handshakes.
module axi_sim_selftest #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    MEM_DEPTH  = 256,
    parameter int                    NUM_TXN    = 16,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
    input  logic        aclk,
    input  logic        aresetn,
    output logic        done,
    output logic        pass,
    output logic [15:0] err_count,
    output logic [15:0] wr_count,
    output logic [15:0] rd_count
);

    localparam int                    IDX_W     = $clog2(MEM_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] MEM_BYTES = ADDR_WIDTH'(MEM_DEPTH * 4);
    localparam logic [15:0]           LAST_IDX  = 16'(NUM_TXN - 1);
    localparam logic [1:0]            RESP_OKAY   = 2'b00;
    localparam logic [1:0]            RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE, ST_WR_ADDR, ST_WR_RESP, ST_RD_ADDR, ST_RD_DATA, ST_DONE
    } state_e;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Master-side channel signals
    logic                  m_awvalid, m_awready, m_wvalid, m_wready;
    logic                  m_bvalid, m_bready, m_arvalid, m_arready;
    logic                  m_rvalid, m_rready;
    logic [ADDR_WIDTH-1:0] m_awaddr, m_araddr;
    logic [DATA_WIDTH-1:0] m_wdata, m_rdata;
    logic [1:0]            m_bresp, m_rresp;

    // Slave-side channel signals
    logic                  s_awvalid, s_awready, s_wvalid, s_wready;
    logic                  s_bvalid, s_bready, s_arvalid, s_arready;
    logic                  s_rvalid, s_rready;
    logic [ADDR_WIDTH-1:0] s_awaddr, s_araddr;
    logic [DATA_WIDTH-1:0] s_wdata, s_rdata;
    logic [1:0]            s_bresp, s_rresp;

    // ------------------------------------------------------------------
    // Master
    // ------------------------------------------------------------------
    state_e                state_q;
    logic [15:0]           idx_q;
    logic [15:0]           err_q;
    logic                  done_q;
    logic                  awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q;
    logic [ADDR_WIDTH-1:0] txn_addr;
    logic [DATA_WIDTH-1:0] txn_data;

    // Address and pattern follow the transaction index, so they stay stable until handshake.
    assign txn_addr  = BASE_ADDR + (ADDR_WIDTH'(idx_q) << 2);
    assign txn_data  = DATA_WIDTH'(32'hC0DE_0000) | DATA_WIDTH'(idx_q);

    assign m_awvalid = awvalid_q;
    assign m_wvalid  = wvalid_q;
    assign m_awaddr  = txn_addr;
    assign m_wdata   = txn_data;
    assign m_bready  = bready_q;
    assign m_arvalid = arvalid_q;
    assign m_araddr  = txn_addr;
    assign m_rready  = rready_q;

    // Sequencer: write all words, read them all back, compare, then park in DONE.
    // NOTE: sequential state is updated with non-blocking assignments only, so every
    // register samples the pre-edge values no matter how the blocks are ordered.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            err_q     <= '0;
            done_q    <= 1'b0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    idx_q     <= '0;
                    awvalid_q <= 1'b1;
                    wvalid_q  <= 1'b1;
                    state_q   <= ST_WR_ADDR;
                end
                ST_WR_ADDR: begin
                    if (m_awvalid && m_awready && m_wvalid && m_wready) begin
                        awvalid_q <= 1'b0;
                        wvalid_q  <= 1'b0;
                        bready_q  <= 1'b1;
                        state_q   <= ST_WR_RESP;
                    end
                end
                ST_WR_RESP: begin
                    if (m_bvalid && m_bready) begin
                        bready_q <= 1'b0;
                        if (m_bresp != RESP_OKAY) err_q <= sat_inc(err_q);
                        if (idx_q == LAST_IDX) begin
                            idx_q     <= '0;
                            arvalid_q <= 1'b1;
                            state_q   <= ST_RD_ADDR;
                        end else begin
                            idx_q     <= idx_q + 16'd1;
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                            state_q   <= ST_WR_ADDR;
                        end
                    end
                end
                ST_RD_ADDR: begin
                    if (m_arvalid && m_arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= ST_RD_DATA;
                    end
                end
                ST_RD_DATA: begin
                    if (m_rvalid && m_rready) begin
                        rready_q <= 1'b0;
                        if (m_rresp != RESP_OKAY || m_rdata != txn_data) err_q <= sat_inc(err_q);
                        if (idx_q == LAST_IDX) begin
                            done_q  <= 1'b1;
                            state_q <= ST_DONE;
                        end else begin
                            idx_q     <= idx_q + 16'd1;
                            arvalid_q <= 1'b1;
                            state_q   <= ST_RD_ADDR;
                        end
                    end
                end
                ST_DONE: state_q <= ST_DONE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign done      = done_q;
    assign pass      = done_q && (err_q == 16'd0);
    assign err_count = err_q;

    // ------------------------------------------------------------------
    // Passthrough monitor
    // ------------------------------------------------------------------
    assign s_awvalid = m_awvalid;
    assign s_awaddr  = m_awaddr;
    assign s_wvalid  = m_wvalid;
    assign s_wdata   = m_wdata;
    assign s_bready  = m_bready;
    assign s_arvalid = m_arvalid;
    assign s_araddr  = m_araddr;
    assign s_rready  = m_rready;
    assign m_awready = s_awready;
    assign m_wready  = s_wready;
    assign m_bvalid  = s_bvalid;
    assign m_bresp   = s_bresp;
    assign m_arready = s_arready;
    assign m_rvalid  = s_rvalid;
    assign m_rdata   = s_rdata;
    assign m_rresp   = s_rresp;

    logic [15:0] wr_count_q, wr_count_d, rd_count_q, rd_count_d;

    assign wr_count_d = (s_awvalid && s_awready) ? sat_inc(wr_count_q) : wr_count_q;
    assign rd_count_d = (s_arvalid && s_arready) ? sat_inc(rd_count_q) : rd_count_q;

    // Saturating handshake counters for the write and read address channels.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_count_q <= '0;
            rd_count_q <= '0;
        end else begin
            wr_count_q <= wr_count_d;
            rd_count_q <= rd_count_d;
        end
    end

    assign wr_count = wr_count_q;
    assign rd_count = rd_count_q;

    // ------------------------------------------------------------------
    // Memory-model slave
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];
    logic                  bvalid_q, rvalid_q;
    logic [1:0]            bresp_q, rresp_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  aw_hs, ar_hs, aw_in_range, ar_in_range;

    // AW and W are only ever accepted together, and only with no response pending.
    assign s_awready   = s_awvalid && s_wvalid && !bvalid_q;
    assign s_wready    = s_awready;
    assign s_arready   = !rvalid_q;
    assign aw_hs       = s_awvalid && s_awready;
    assign ar_hs       = s_arvalid && s_arready;
    assign aw_in_range = s_awaddr < MEM_BYTES;
    assign ar_in_range = s_araddr < MEM_BYTES;

    // Response channels: one-cycle latency after the address handshake, held until accepted.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            bvalid_q <= 1'b0;
            bresp_q  <= RESP_OKAY;
            rvalid_q <= 1'b0;
            rresp_q  <= RESP_OKAY;
            rdata_q  <= '0;
        end else begin
            if (aw_hs) begin
                bvalid_q <= 1'b1;
                bresp_q  <= aw_in_range ? RESP_OKAY : RESP_SLVERR;
            end else if (s_bvalid && s_bready) begin
                bvalid_q <= 1'b0;
            end
            if (ar_hs) begin
                rvalid_q <= 1'b1;
                rresp_q  <= ar_in_range ? RESP_OKAY : RESP_SLVERR;
                rdata_q  <= ar_in_range ? mem_q[s_araddr[IDX_W+1:2]] : '0;
            end else if (s_rvalid && s_rready) begin
                rvalid_q <= 1'b0;
            end
        end
    end

    // Storage array: in-range writes land on the AW/W handshake edge.
    // NOTE: the memory has no reset branch; contents survive reset and stay a plain RAM.
    always_ff @(posedge aclk) begin
        if (aw_hs && aw_in_range) mem_q[s_awaddr[IDX_W+1:2]] <= s_wdata;
    end

    assign s_bvalid = bvalid_q;
    assign s_bresp  = bresp_q;
    assign s_rvalid = rvalid_q;
    assign s_rresp  = rresp_q;
    assign s_rdata  = rdata_q;

endmodule

// File: tb/tb_axi_sim_selftest.sv
// Directed bench for axi_sim_selftest: default run, single transaction,
// out-of-range window, mid-sequence reset, post-done hold, protocol monitor.
module tb_axi_sim_selftest;

    logic        aclk = 1'b0;
    logic        rst_def, rst_one, rst_oob;
    logic        done_def, pass_def, done_one, pass_one, done_oob, pass_oob;
    logic [15:0] err_def, wr_def, rd_def;
    logic [15:0] err_one, wr_one, rd_one;
    logic [15:0] err_oob, wr_oob, rd_oob;

    int errors = 0;
    int checks = 0;

    always #10 aclk = ~aclk;

    axi_sim_selftest u_def (
        .aclk(aclk), .aresetn(rst_def), .done(done_def), .pass(pass_def),
        .err_count(err_def), .wr_count(wr_def), .rd_count(rd_def)
    );

    axi_sim_selftest #(.NUM_TXN(1)) u_one (
        .aclk(aclk), .aresetn(rst_one), .done(done_one), .pass(pass_one),
        .err_count(err_one), .wr_count(wr_one), .rd_count(rd_one)
    );

    axi_sim_selftest #(.BASE_ADDR(32'h3F8), .MEM_DEPTH(256)) u_oob (
        .aclk(aclk), .aresetn(rst_oob), .done(done_oob), .pass(pass_oob),
        .err_count(err_oob), .wr_count(wr_oob), .rd_count(rd_oob)
    );

    // Protocol monitor on the default instance, sampled mid-cycle
    int          proto_viol = 0;
    int          hs_total   = 0;
    int          outst      = 0;
    logic        aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic        p_awv, p_awr, p_arv, p_arr, p_aw_hs, p_ar_hs, p_bv, p_rv;
    logic [31:0] p_awaddr, p_araddr;

    always @(negedge aclk) begin
        if (!rst_def) begin
            p_awv = 0; p_awr = 0; p_arv = 0; p_arr = 0;
            p_aw_hs = 0; p_ar_hs = 0; p_bv = 0; p_rv = 0;
            p_awaddr = '0; p_araddr = '0; outst = 0;
        end else begin
            aw_hs = u_def.m_awvalid && u_def.m_awready;
            w_hs  = u_def.m_wvalid && u_def.m_wready;
            b_hs  = u_def.m_bvalid && u_def.m_bready;
            ar_hs = u_def.m_arvalid && u_def.m_arready;
            r_hs  = u_def.m_rvalid && u_def.m_rready;
            if (aw_hs != w_hs) proto_viol++;
            if (p_awv && !p_awr && (!u_def.m_awvalid || !u_def.m_wvalid || u_def.m_awaddr != p_awaddr)) proto_viol++;
            if (p_arv && !p_arr && (!u_def.m_arvalid || u_def.m_araddr != p_araddr)) proto_viol++;
            if ((u_def.m_bvalid && !p_bv) != p_aw_hs) proto_viol++;
            if ((u_def.m_rvalid && !p_rv) != p_ar_hs) proto_viol++;
            if ((aw_hs || ar_hs) && outst != 0) proto_viol++;
            if (aw_hs && ar_hs) proto_viol++;
            outst = outst + int'(aw_hs) + int'(ar_hs) - int'(b_hs) - int'(r_hs);
            hs_total = hs_total + int'(aw_hs) + int'(ar_hs);
            p_awv = u_def.m_awvalid; p_awr = u_def.m_awready; p_awaddr = u_def.m_awaddr;
            p_arv = u_def.m_arvalid; p_arr = u_def.m_arready; p_araddr = u_def.m_araddr;
            p_aw_hs = aw_hs; p_ar_hs = ar_hs;
            p_bv = u_def.m_bvalid; p_rv = u_def.m_rvalid;
        end
    end

    // 65 edges after release of the default instance, then the final status.
    task automatic run_default(input string tag);
        logic early = 1'b0;
        for (int e = 1; e <= 65; e++) begin
            @(posedge aclk); #1;
            if (e < 65 && done_def) early = 1'b1;
        end
        checks++; if (early !== 1'b0) begin errors++; $display("FAIL %s_done_early: got %b expected 0", tag, early); end
        checks++; if (done_def !== 1'b1) begin errors++; $display("FAIL %s_done_edge65: got %b expected 1", tag, done_def); end
        checks++; if (pass_def !== 1'b1) begin errors++; $display("FAIL %s_pass: got %b expected 1", tag, pass_def); end
        checks++; if (err_def !== 16'd0) begin errors++; $display("FAIL %s_err_count: got %0d expected 0", tag, err_def); end
        checks++; if (wr_def !== 16'd16) begin errors++; $display("FAIL %s_wr_count: got %0d expected 16", tag, wr_def); end
        checks++; if (rd_def !== 16'd16) begin errors++; $display("FAIL %s_rd_count: got %0d expected 16", tag, rd_def); end
        checks++; if (proto_viol !== 0) begin errors++; $display("FAIL %s_protocol: got %0d violations expected 0", tag, proto_viol); end
    endtask

    task automatic test_reset;
        rst_def = 1'b0; rst_one = 1'b0; rst_oob = 1'b0;
        #1;
        checks++; if (done_def !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done_def); end
        checks++; if (pass_def !== 1'b0) begin errors++; $display("FAIL reset_pass: got %b expected 0", pass_def); end
        checks++; if ({err_def, wr_def, rd_def} !== 48'd0) begin errors++; $display("FAIL reset_counts: got %0d/%0d/%0d expected 0/0/0", err_def, wr_def, rd_def); end
        checks++; if (u_def.m_bvalid !== 1'b0 || u_def.m_rvalid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid: got b=%b r=%b expected 0 0", u_def.m_bvalid, u_def.m_rvalid); end
        repeat (5) @(negedge aclk);  // t = 100 ns
        rst_def = 1'b1;
    endtask

    task automatic test_default_sequence;
        run_default("default");
    endtask

    task automatic test_hold_after_done;
        logic [49:0] snap;
        int          hs0;
        logic        changed = 1'b0;
        snap = {done_def, pass_def, err_def, wr_def, rd_def};
        hs0  = hs_total;
        repeat (100) begin
            @(posedge aclk); #1;
            if ({done_def, pass_def, err_def, wr_def, rd_def} !== snap) changed = 1'b1;
        end
        checks++; if (changed !== 1'b0) begin errors++; $display("FAIL hold_outputs_stable: got changed=%b expected 0", changed); end
        checks++; if (hs_total !== hs0) begin errors++; $display("FAIL hold_no_handshakes: got %0d expected %0d", hs_total, hs0); end
    endtask

    task automatic test_mid_reset;
        rst_def = 1'b0;
        repeat (2) @(negedge aclk);
        rst_def = 1'b1;
        repeat (20) @(posedge aclk);
        #1;
        checks++; if (wr_def !== 16'd10) begin errors++; $display("FAIL midrst_wr_at_edge20: got %0d expected 10", wr_def); end
        #4;
        rst_def = 1'b0;
        #1;
        checks++; if ({done_def, pass_def, err_def, wr_def, rd_def} !== 50'd0) begin
            errors++; $display("FAIL midrst_async_clear: got done=%b pass=%b err=%0d wr=%0d rd=%0d expected all 0", done_def, pass_def, err_def, wr_def, rd_def);
        end
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        rst_def = 1'b1;
        run_default("midrst");
    endtask

    task automatic test_single_txn;
        logic early = 1'b0;
        @(negedge aclk);
        rst_one = 1'b1;
        for (int e = 1; e <= 5; e++) begin
            @(posedge aclk); #1;
            if (e < 5 && done_one) early = 1'b1;
        end
        checks++; if (early !== 1'b0) begin errors++; $display("FAIL single_done_early: got %b expected 0", early); end
        checks++; if (done_one !== 1'b1) begin errors++; $display("FAIL single_done_edge5: got %b expected 1", done_one); end
        checks++; if (pass_one !== 1'b1) begin errors++; $display("FAIL single_pass: got %b expected 1", pass_one); end
        checks++; if (wr_one !== 16'd1 || rd_one !== 16'd1) begin errors++; $display("FAIL single_counts: got wr=%0d rd=%0d expected 1 1", wr_one, rd_one); end
        checks++; if (u_one.mem_q[0] !== 32'hC0DE_0000) begin errors++; $display("FAIL single_mem0: got %h expected c0de0000", u_one.mem_q[0]); end
    endtask

    task automatic test_out_of_range;
        logic early = 1'b0;
        @(negedge aclk);
        rst_oob = 1'b1;
        for (int e = 1; e <= 65; e++) begin
            @(posedge aclk); #1;
            if (e < 65 && done_oob) early = 1'b1;
        end
        checks++; if (early !== 1'b0) begin errors++; $display("FAIL oob_done_early: got %b expected 0", early); end
        checks++; if (done_oob !== 1'b1) begin errors++; $display("FAIL oob_done_edge65: got %b expected 1", done_oob); end
        checks++; if (err_oob !== 16'd28) begin errors++; $display("FAIL oob_err_count: got %0d expected 28", err_oob); end
        checks++; if (pass_oob !== 1'b0) begin errors++; $display("FAIL oob_pass: got %b expected 0", pass_oob); end
        checks++; if (wr_oob !== 16'd16 || rd_oob !== 16'd16) begin errors++; $display("FAIL oob_counts: got wr=%0d rd=%0d expected 16 16", wr_oob, rd_oob); end
        checks++; if (u_oob.mem_q[255] !== 32'hC0DE_0001) begin errors++; $display("FAIL oob_mem255: got %h expected c0de0001", u_oob.mem_q[255]); end
    endtask

    initial begin
        test_reset();
        test_default_sequence();
        test_hold_after_done();
        test_mid_reset();
        test_single_txn();
        test_out_of_range();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
